// File: rtl/mul_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// mul_div_ctrl_if
// Bundle between the execute stage and the multiply/divide sequencer.
//
// Signals
//   start_i    E-stage instruction is a valid MULT/MULTU/DIV/DIVU
//   op_i       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i   rs / rt operand values after forwarding
//   flush_i    exception flush, aborts any operation in progress
//   stall_o    hold request towards the hazard unit (mut_div_stallE)
//   busy_o     sequencer is in its multiply or divide phase
//   hilo_we_o  one-cycle HI/LO write strobe
//   hi_o, lo_o result words, meaningful only while hilo_we_o is high
//
// Modports
//   master  pipeline side (drives the request, observes the result)
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface mul_div_ctrl_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, busy_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_ctrl.sv
// -----------------------------------------------------------------------------
// mul_div_ctrl
// Execute-stage multiply/divide sequencer for the MIPS pipeline. A MULT/MULTU
// is computed in one shot and written back two cycles after the start cycle;
// a DIV/DIVU runs a 32-step restoring divide on operand magnitudes and fixes
// the signs on the way out. The hazard unit is stalled while the operation is
// in flight, and an exception flush abandons it without writing HI/LO.
//
// Ports
//   clk     pipeline clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     mul_div_ctrl_if.slave (request, stall, busy, HI/LO write)
//
// Parameters
//   DIV_ITERS  divide iteration count, equal to the operand width (32)
//
// Build option
//   MULDIV_DIV_ZERO_FAST_EN  when defined, a divide by zero skips the
//   iterative phase and writes the (identical) result one cycle after start.
// -----------------------------------------------------------------------------
module mul_div_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic           clk,
  input  logic           resetn,
  mul_div_ctrl_if.slave  bus
);

  localparam int             CW        = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [63:0]   r_prod;
  logic [31:0]   r_rem;
  logic [31:0]   r_quot;
  logic [31:0]   r_divisor;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [CW-1:0] r_count;
  logic          r_negQ;
  logic          r_negR;

  logic          w_isSigned;
  logic [63:0]   w_prodS;
  logic [63:0]   w_prodU;
  logic [31:0]   w_absA;
  logic [31:0]   w_absB;
  logic [32:0]   w_remShift;
  logic [32:0]   w_remDiff;
  logic          w_geq;
  logic [31:0]   w_remNext;
  logic [31:0]   w_quotNext;
  logic [31:0]   w_hiDiv;
  logic [31:0]   w_loDiv;

  // Operand preparation for the start cycle. op_i[0] clear means the signed
  // flavour of either MULT or DIV. Sign-extending both factors to 64 bits and
  // keeping the low 64 bits of the product gives the exact signed product.
  assign w_isSigned = ~bus.op_i[0];
  assign w_prodS    = {{32{bus.a_i[31]}}, bus.a_i} * {{32{bus.b_i[31]}}, bus.b_i};
  assign w_prodU    = {32'd0, bus.a_i} * {32'd0, bus.b_i};
  assign w_absA     = (w_isSigned && bus.a_i[31]) ? (32'd0 - bus.a_i) : bus.a_i;
  assign w_absB     = (w_isSigned && bus.b_i[31]) ? (32'd0 - bus.b_i) : bus.b_i;

  // One restoring divide step. The partial remainder is kept 33 bits wide
  // during the compare so divisors with bit 31 set (e.g. 0x80000000 from
  // |INT_MIN|, or large DIVU divisors) still divide correctly.
  assign w_remShift = {r_rem, r_quot[31]};
  assign w_remDiff  = w_remShift - {1'b0, r_divisor};
  assign w_geq      = (w_remShift >= {1'b0, r_divisor});
  assign w_remNext  = 32'(w_geq ? w_remDiff : w_remShift);
  assign w_quotNext = {r_quot[30:0], w_geq};

  // Sign fix-up applied as the final step's result is captured.
  assign w_loDiv = r_negQ ? (32'd0 - w_quotNext) : w_quotNext;
  assign w_hiDiv = r_negR ? (32'd0 - w_remNext)  : w_remNext;

  // Sequencer state machine. HI/LO are captured on the transition into DONE
  // so they are already stable during the write cycle. A flush wins over
  // every state and simply returns to IDLE; the datapath registers are left
  // as they are because nothing reads them outside an operation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
    end else if (bus.flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            if (!bus.op_i[1]) begin
              r_prod  <= w_isSigned ? w_prodS : w_prodU;
              r_state <= MUL;
            end else begin
              r_divisor <= w_absB;
              r_quot    <= w_absA;
              r_rem     <= '0;
              r_count   <= '0;
              r_negQ    <= w_isSigned & (bus.a_i[31] ^ bus.b_i[31]);
              r_negR    <= w_isSigned & bus.a_i[31];
`ifdef MULDIV_DIV_ZERO_FAST_EN
              // Divide by zero: an all-ones quotient and remainder |a|,
              // sign-fixed, reduce to hi=a and lo=+1/-1 depending on a.
              if (bus.b_i == 32'd0) begin
                r_hi    <= bus.a_i;
                r_lo    <= (w_isSigned && bus.a_i[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
                r_state <= DONE;
              end else begin
                r_state <= DIV;
              end
`else
              r_state <= DIV;
`endif
            end
          end
        end
        MUL: begin
          r_hi    <= r_prod[63:32];
          r_lo    <= r_prod[31:0];
          r_state <= DONE;
        end
        DIV: begin
          r_rem   <= w_remNext;
          r_quot  <= w_quotNext;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_STEP) begin
            r_hi    <= w_hiDiv;
            r_lo    <= w_loDiv;
            r_state <= DONE;
          end
        end
        DONE: begin
          // start_i here belongs to the instruction now leaving E.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The stall is combinational so the instruction is held from its very first
  // E cycle; a flush drops it in the same cycle.
  assign bus.stall_o   = (((r_state == IDLE) && bus.start_i) ||
                          (r_state == MUL) || (r_state == DIV)) && !bus.flush_i;
  assign bus.busy_o    = (r_state == MUL) || (r_state == DIV);
  assign bus.hilo_we_o = (r_state == DONE) && !bus.flush_i;
  assign bus.hi_o      = r_hi;
  assign bus.lo_o      = r_lo;

endmodule

// File: doc/mul_div_ctrl.md
# mul_div_ctrl

Execute-stage multiply/divide sequencer for the MIPS pipeline. Accepts one MULT/MULTU/DIV/DIVU per start, runs a 2-cycle multiply or a 32-iteration restoring divide, and drives the `mut_div_stallE` stall input of the hazard unit while busy. Produces one-cycle HI/LO write results. An exception flush aborts it at any point.

## Interface
- `DIV_ITERS`, default 32: divide iteration count; equals operand width; not intended to change.
- `clk`  in  1  pipeline clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start_i`  in  1  E-stage instruction is a mul/div op and valid
- `op_i`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start_i` in IDLE
- `a_i`, `b_i`  in  32 each  rs / rt operand values (after forwarding); sampled with `op_i`
- `flush_i`  in  1  exception flush (`flush_except`)
- `stall_o`  out  1  to hazard `mut_div_stallE`
- `busy_o`  out  1  state is MUL or DIV
- `hilo_we_o`  out  1  one-cycle HI/LO write strobe
- `hi_o`, `lo_o`  out  32 each  result; valid only when `hilo_we_o`=1

## Operation
- States: IDLE, MUL, DIV, DONE. Reset and flush force IDLE.
- IDLE: if `start_i` & !`flush_i`:
  - MULT/MULTU: register the 64-bit product (signed or unsigned); go to MUL.
  - DIV/DIVU: register |a|, |b| (abs only for DIV), sign of a, and sign of a^b; clear remainder; count=0; go to DIV.
- MUL: go to DONE.
- DIV: each cycle performs one restoring step: rem={rem[30:0],quot[31]}, quot<<=1; if rem>=divisor then rem-=divisor and quot[0]=1. count++. After step 32, go to DONE.
- DONE: `hilo_we_o`=1.
  - Multiply: hi/lo = product[63:32]/[31:0].
  - Divide: lo = quotient, negated if the a^b sign is 1 (DIV only); hi = remainder, negated if a was negative (DIV only).
  - `start_i` is ignored in DONE, because the same instruction is leaving E this cycle. Next state is IDLE.
- `stall_o` = ((IDLE & `start_i`) | MUL | DIV) & !`flush_i`. It is combinational, so the instruction is held in E from its first cycle.
- Divide by zero, normal path: DIVU x/0 gives lo=0xFFFFFFFF, hi=x. DIV gives the sign-fixed result of the same algorithm. No exception is raised.
- `hilo_we_o` is suppressed (forced 0) when `flush_i`=1 in DONE.

## Timing
- Reset values: state IDLE; `stall_o`=0 (when `start_i`=0); `busy_o`=0; `hilo_we_o`=0; `hi_o`=`lo_o`=0; all internal registers 0.
- The start edge is cycle T (IDLE with `start_i`).
- Multiply: `stall_o`=1 in cycles T and T+1. DONE and `hilo_we_o` at T+2. 3-cycle occupancy.
- Divide: `stall_o`=1 in T..T+32 (33 cycles). DONE at T+33.
- Back-to-back ops: a new start is accepted at the earliest in the cycle after DONE.
- Flush in any state: `stall_o` drops in the same cycle, state is IDLE the next cycle, and no write occurs.
- `resetn` low mid-operation: immediate abort to reset values; no write.
- `a_i`/`b_i` changes after cycle T have no effect.

## Configuration
- `MULDIV_DIV_ZERO_FAST_EN` defined:
  - DIV/DIVU with `b_i`=0 in IDLE goes directly to DONE at T+1.
  - `stall_o`=1 only in cycle T.
  - Results: DIVU gives hi=a, lo=0xFFFFFFFF. DIV gives hi=a, lo = 0x00000001 if a<0, else 0xFFFFFFFF. These match the normal-path values.
- Macro undefined: divide by zero takes the full 33-cycle path with identical results.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → stall high 2 cycles; at T+2 `hilo_we_o`=1, hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFE (−2), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+2.
- DIV a=−7 (0xFFFFFFF9), b=2 → stall 33 cycles; at T+33 lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 100/7 → lo=14, hi=2.
- DIV started, `flush_i` pulsed at T+10 → `stall_o`=0 that cycle, no `hilo_we_o` ever. A new MULTU 3×4 two cycles later → lo=12.
- DIVU 5/0 → hi=5, lo=0xFFFFFFFF; write at T+1 with `MULDIV_DIV_ZERO_FAST_EN`, at T+33 without.
- `resetn` asserted at T+5 of a DIV → all outputs 0 immediately. After release, `start_i` held high into DONE starts no second operation.
